router_output_ctrl: RTL
=======================

ROUTER_OUTPUT_CTRL -- requirements
Module: router_output_ctrl

Interface
REQ-001 Parameter NUM_PORTS, 5, number of input requesters: 0=N, 1=S, 2=E, 3=W, 4=PE.
REQ-002 Parameter FLIT_W, 64, flit width; bit FLIT_W-1 is the VC bit.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 polarity  in  1  cycle parity; internal VC = polarity, link VC = ~polarity.
REQ-006 req_i  in  NUM_PORTS  per-input head-flit valid.
REQ-007 din_i  in  NUM_PORTS*FLIT_W  head flits; input k occupies bits [k*FLIT_W +: FLIT_W].
REQ-008 gnt_o  out  NUM_PORTS  one-hot grant; input pops its head flit on the same edge.
REQ-009 so_o  out  1  link send-valid to downstream.
REQ-010 do_o  out  FLIT_W  link flit.
REQ-011 ro_i  in  1  downstream ready.

Function
REQ-012 Two 1-entry output buffers, buf[0] (even VC) and buf[1] (odd VC), each with a full flag.
REQ-013 Eligible set = inputs k with req_i[k]=1 and din_i VC bit == polarity.
REQ-014 gnt_o is combinational: one-hot to the first eligible input at or after rr_ptr[polarity], searching upward with wrap 4->0; all-zero if buf[polarity] is full or the eligible set is empty.
REQ-015 On a grant edge, the granted flit is written to buf[polarity] unmodified except hop field [55:48], which decrements by 1 and saturates at 0.
REQ-016 On a grant edge, rr_ptr[polarity] <= (granted index + 1) mod NUM_PORTS; with no grant it holds.
REQ-017 rr_ptr[0] and rr_ptr[1] are independent; a grant on one VC never moves the other pointer.
REQ-018 so_o = full[~polarity]; do_o = buf[~polarity] when so_o=1, else all-zero.
REQ-019 Link transfer occurs when so_o=1 and ro_i=1 at the edge; full[~polarity] clears on that edge.
REQ-020 so_o remains asserted and do_o remains stable across consecutive link-VC phases until the transfer completes.
REQ-021 Fill and drain never target the same buffer in one cycle; both may occur on the same edge on different buffers.
REQ-022 Grant-to-link latency is 1 cycle minimum: a flit granted in a polarity=P cycle is offered in the next cycle (polarity = ~P).
REQ-023 Requests with a mismatched VC bit are ignored; they are not an error and no flit is dropped.

Reset
REQ-024 While reset=0, all of the following hold asynchronously: full[1:0]=0, buf=0, rr_ptr[0]=rr_ptr[1]=0, so_o=0, do_o=0, gnt_o=0.
REQ-025 Reset asserted mid-transfer discards buffered flits without asserting so_o.
REQ-026 The first grant after reset deassertion follows the REQ-014 rules with pointer 0.

Structure
REQ-027 Shared package noc_pkg holds NUM_PORTS, FLIT_W, port-index constants (PORT_N..PORT_PE), VC_BIT=63, HOP_LSB=48 and HOP_MSB=55.
REQ-028 Sub-module rr_arbiter5 contains the pointer, the eligibility mask and the one-hot grant logic, and is instantiated once per VC; gnt_o is the polarity-selected output.
REQ-029 Total RTL is 120-400 lines; no memories or latches.

Verification
REQ-030 Scenario 1: reset low for 100 ns, then PE input flit {vc=0, hop=8'h03, payload 48'hDEADBEEF1234} in a polarity=0 cycle, ro_i=1 -> gnt_o=5'b10000 that cycle; next cycle so_o=1 with do_o hop=8'h02, payload unchanged.
REQ-031 Scenario 2: all 5 inputs request vc=0 continuously, ro_i=1 -> successive even-phase grants N,S,E,W,PE,N (wrap verified), one per even cycle.
REQ-032 Scenario 3: ro_i=0 with buf[0] full, E requesting vc=0 -> gnt_o=0 every even cycle and so_o/do_o stable in odd cycles; ro_i=1 -> transfer, then E is granted in the next even cycle.
REQ-033 Scenario 4: same edge, odd-phase link transfer of buf[1] while W is granted into buf[0] -> both complete and rr_ptr[1] is unchanged.
REQ-034 Scenario 5: hop=8'h00 flit granted -> forwarded hop=8'h00 (saturation); a vc=1 request during an even cycle -> no grant.
REQ-035 Scenario 6: reset pulsed low while so_o=1 -> so_o=0 immediately and both buffers empty after release.

Source files
------------

// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared constants and flit helpers for the router output controller
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int FLIT_W    = 64;

    localparam int PORT_N  = 0;
    localparam int PORT_S  = 1;
    localparam int PORT_E  = 2;
    localparam int PORT_W  = 3;
    localparam int PORT_PE = 4;

    localparam int VC_BIT  = 63;
    localparam int HOP_LSB = 48;
    localparam int HOP_MSB = 55;

    // Hop count drops by one per router and never wraps below zero.
    function automatic logic [FLIT_W-1:0] dec_hop(input logic [FLIT_W-1:0] flit);
        logic [FLIT_W-1:0] res;
        res = flit;
        if (flit[HOP_MSB:HOP_LSB] != 8'h00) begin
            res[HOP_MSB:HOP_LSB] = flit[HOP_MSB:HOP_LSB] - 8'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter5.sv
// rtl/rr_arbiter5.sv - round-robin arbiter for one virtual channel
module rr_arbiter5
    import noc_pkg::*;
#(
    parameter int   NUM_PORTS = noc_pkg::NUM_PORTS,
    parameter logic VC        = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 active,
    input  logic                 blocked,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] vc_bits,
    output logic [NUM_PORTS-1:0] gnt
);

    localparam int PW = $clog2(NUM_PORTS);

    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        nxt_ptr;
    logic [NUM_PORTS-1:0] elig;
    logic                 found;
    logic [PW-1:0]        idx_w;
    int                   idx;

    // Only heads whose VC bit matches this arbiter's channel may compete.
    assign elig = req & (VC ? vc_bits : ~vc_bits);

    // First eligible input at or above the pointer wins, wrapping past the top port.
    always_comb begin
        gnt     = '0;
        nxt_ptr = rr_ptr;
        found   = 1'b0;
        idx     = 0;
        idx_w   = '0;
        if (active && !blocked) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                idx   = (int'(rr_ptr) + i) % NUM_PORTS;
                idx_w = PW'(idx);
                if (!found && elig[idx_w]) begin
                    found      = 1'b1;
                    gnt[idx_w] = 1'b1;
                    nxt_ptr    = PW'((idx + 1) % NUM_PORTS);
                end
            end
        end
    end

    // Pointer moves past the winner only when this channel actually grants.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (|gnt) begin
            rr_ptr <= nxt_ptr;
        end
    end

endmodule

// File: rtl/router_output_ctrl.sv
// rtl/router_output_ctrl.sv - two-VC output port: arbitrate inputs, buffer, drive link
module router_output_ctrl
    import noc_pkg::*;
#(
    parameter int NUM_PORTS = noc_pkg::NUM_PORTS,
    parameter int FLIT_W    = noc_pkg::FLIT_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        polarity,
    input  logic [NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS*FLIT_W-1:0] din_i,
    output logic [NUM_PORTS-1:0]        gnt_o,
    output logic                        so_o,
    output logic [FLIT_W-1:0]           do_o,
    input  logic                        ro_i
);

    logic [1:0][FLIT_W-1:0] buf_q;
    logic [1:0]             full_q;
    logic [NUM_PORTS-1:0]   vc_bits;
    logic [NUM_PORTS-1:0]   gnt_vc0;
    logic [NUM_PORTS-1:0]   gnt_vc1;
    logic [NUM_PORTS-1:0]   gnt_sel;
    logic [FLIT_W-1:0]      gnt_flit;
    logic                   link_vc;

    assign link_vc = ~polarity;

    for (genvar k = 0; k < NUM_PORTS; k++) begin : g_vc
        assign vc_bits[k] = din_i[k*FLIT_W + VC_BIT];
    end

    rr_arbiter5 #(.NUM_PORTS(NUM_PORTS), .VC(1'b0)) u_arb_vc0 (
        .clk     (clk),
        .reset   (reset),
        .active  (~polarity),
        .blocked (full_q[0]),
        .req     (req_i),
        .vc_bits (vc_bits),
        .gnt     (gnt_vc0)
    );

    rr_arbiter5 #(.NUM_PORTS(NUM_PORTS), .VC(1'b1)) u_arb_vc1 (
        .clk     (clk),
        .reset   (reset),
        .active  (polarity),
        .blocked (full_q[1]),
        .req     (req_i),
        .vc_bits (vc_bits),
        .gnt     (gnt_vc1)
    );

    // Grant is held low while reset is asserted so no input pops a flit.
    assign gnt_sel = (reset && polarity)  ? gnt_vc1 :
                     (reset && !polarity) ? gnt_vc0 : '0;
    assign gnt_o   = gnt_sel;

    assign so_o = full_q[link_vc];
    assign do_o = so_o ? buf_q[link_vc] : '0;

    // One-hot select of the winning head flit.
    always_comb begin
        gnt_flit = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt_sel[k]) begin
                gnt_flit = gnt_flit | din_i[k*FLIT_W +: FLIT_W];
            end
        end
    end

    // Fill the internal-VC buffer on grant and drain the link-VC buffer on handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            buf_q  <= '0;
            full_q <= '0;
        end else begin
            if (|gnt_sel) begin
                buf_q[polarity]  <= dec_hop(gnt_flit);
                full_q[polarity] <= 1'b1;
            end
            if (so_o && ro_i) begin
                full_q[link_vc] <= 1'b0;
            end
        end
    end

endmodule
